// File: rtl/move_debouncer.sv
// Five-button debouncer for a falling-block game: synchronizes and debounces the raw
// pushbuttons, turns presses into one-cycle move strobes and auto-repeats right/left/down.
module move_debouncer #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [2:0] move_o,
    output logic       move_valid_o,
    output logic [4:0] held_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RC_W = $clog2(REPEAT_DELAY + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] RPT_FIRE   = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RPT_RELOAD = RC_W'(REPEAT_DELAY - REPEAT_RATE);

    localparam int B_RIGHT = 0;
    localparam int B_LEFT  = 1;
    localparam int B_ROR   = 2;
    localparam int B_ROL   = 3;
    localparam int B_DOWN  = 4;

    localparam logic [2:0] MV_RIGHT = 3'b000;
    localparam logic [2:0] MV_LEFT  = 3'b001;
    localparam logic [2:0] MV_ROR   = 3'b010;
    localparam logic [2:0] MV_ROL   = 3'b011;
    localparam logic [2:0] MV_DOWN  = 3'b100;
    localparam logic [2:0] MV_NONE  = 3'b111;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'b00,
        OWN_RIGHT = 2'b01,
        OWN_LEFT  = 2'b10,
        OWN_DOWN  = 2'b11
    } owner_t;

    logic [4:0]      sync1_r;
    logic [4:0]      sync2_r;
    logic [4:0]      stable_r;
    logic [4:0]      stable_d_r;
    logic [DB_W-1:0] db_cnt_r [5];
    logic [4:0]      press_s;

    owner_t          owner_r;
    owner_t          owner_nxt_s;
    logic [RC_W-1:0] rpt_cnt_r;
    logic [RC_W-1:0] rpt_cnt_nxt_s;
    logic            owner_held_s;
    logic            rpt_evt_s;

    logic [2:0]      move_s;
    logic            valid_s;

    // Synchronizer, per-bit debounce counters and the one-cycle-delayed stable copy
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 5'b00000;
            sync2_r    <= 5'b00000;
            stable_r   <= 5'b00000;
            stable_d_r <= 5'b00000;
            for (int i = 0; i < 5; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            sync1_r    <= btn_raw;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            for (int i = 0; i < 5; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else if (db_cnt_r[i] == DB_LAST) begin
                    stable_r[i] <= ~stable_r[i];
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    assign press_s = stable_r & ~stable_d_r;
    assign held_o  = stable_r;

    // Repeat-owner state register
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r   <= OWN_NONE;
            rpt_cnt_r <= {RC_W{1'b0}};
        end else begin
            owner_r   <= owner_nxt_s;
            rpt_cnt_r <= rpt_cnt_nxt_s;
        end
    end

    // Level of the owning button; a repeat fires only while it is still held
    always_comb begin
        case (owner_r)
            OWN_RIGHT: owner_held_s = stable_r[B_RIGHT];
            OWN_LEFT:  owner_held_s = stable_r[B_LEFT];
            OWN_DOWN:  owner_held_s = stable_r[B_DOWN];
            default:   owner_held_s = 1'b0;
        endcase
        rpt_evt_s = owner_held_s && (rpt_cnt_r == RPT_FIRE);
    end

    // Owner next state; the counter reloads after each repeat so it never overflows
    always_comb begin
        owner_nxt_s   = owner_r;
        rpt_cnt_nxt_s = rpt_cnt_r;
        if (press_s[B_DOWN]) begin
            owner_nxt_s   = OWN_DOWN;
            rpt_cnt_nxt_s = {RC_W{1'b0}};
        end else if (press_s[B_LEFT]) begin
            owner_nxt_s   = OWN_LEFT;
            rpt_cnt_nxt_s = {RC_W{1'b0}};
        end else if (press_s[B_RIGHT]) begin
            owner_nxt_s   = OWN_RIGHT;
            rpt_cnt_nxt_s = {RC_W{1'b0}};
        end else if (!owner_held_s) begin
            owner_nxt_s   = OWN_NONE;
            rpt_cnt_nxt_s = {RC_W{1'b0}};
        end else if (rpt_evt_s) begin
            rpt_cnt_nxt_s = RPT_RELOAD;
        end else begin
            rpt_cnt_nxt_s = rpt_cnt_r + RC_W'(1);
        end
    end

    // Event arbitration: presses by fixed priority, then the owner's repeat
    always_comb begin
        move_s  = MV_NONE;
        valid_s = 1'b1;
        if (press_s[B_DOWN]) begin
            move_s = MV_DOWN;
        end else if (press_s[B_ROR]) begin
            move_s = MV_ROR;
        end else if (press_s[B_ROL]) begin
            move_s = MV_ROL;
        end else if (press_s[B_LEFT]) begin
            move_s = MV_LEFT;
        end else if (press_s[B_RIGHT]) begin
            move_s = MV_RIGHT;
        end else if (rpt_evt_s) begin
            case (owner_r)
                OWN_RIGHT: move_s = MV_RIGHT;
                OWN_LEFT:  move_s = MV_LEFT;
                OWN_DOWN:  move_s = MV_DOWN;
                default:   move_s = MV_NONE;
            endcase
        end else begin
            valid_s = 1'b0;
        end
    end

    // Registered move outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            move_o       <= MV_NONE;
            move_valid_o <= 1'b0;
        end else begin
            move_o       <= move_s;
            move_valid_o <= valid_s;
        end
    end

endmodule
